// File: rtl/fp_mac_accumulator.sv
// fp_mac_accumulator: sums KERNEL_SIZE signed fixed-point products plus a
// per-window bias in a guarded accumulator. The window sum is saturated back
// to the data format and held on a valid/ready output until it is taken.
module fp_mac_accumulator #(
  parameter int INTEGER     = 2,
  parameter int FRACTION    = 14,
  parameter int KERNEL_SIZE = 9,
  parameter int GUARD       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INTEGER+FRACTION-1:0]   in_data,
  input  logic [INTEGER+FRACTION-1:0]   bias,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INTEGER+FRACTION-1:0]   out_data,
  output logic                          out_sat
);

  localparam int W  = INTEGER + FRACTION;
  localparam int AW = W + GUARD;
  localparam int CW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic [AW-1:0]   acc_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [W-1:0]    out_data_r;
  logic            out_sat_r;

  logic [AW-1:0]   ext_data_s;
  logic [AW-1:0]   ext_bias_s;
  logic [AW-1:0]   base_s;
  logic [AW-1:0]   sum_s;
  logic            last_s;
  logic [W:0]      sat_s;

  // Clip a guarded sum to the data width; MSB of the result flags clipping.
  // The sum fits when its top GUARD+1 bits are all copies of the sign bit.
  function automatic logic [W:0] sat_fn(input logic [AW-1:0] s);
    logic [GUARD:0] top;
    logic [W:0]     res;
    top = s[AW-1:W-1];
    if (!s[AW-1] && (top != {(GUARD+1){1'b0}})) begin
      res = {1'b1, 1'b0, {(W-1){1'b1}}};
    end else if (s[AW-1] && (top != {(GUARD+1){1'b1}})) begin
      res = {1'b1, 1'b1, {(W-1){1'b0}}};
    end else begin
      res = {1'b0, s[W-1:0]};
    end
    return res;
  endfunction

  // Running-sum datapath: the first beat of a window starts from the bias.
  always_comb begin
    ext_data_s = {{GUARD{in_data[W-1]}}, in_data};
    ext_bias_s = {{GUARD{bias[W-1]}}, bias};
    if (count_r == CNT_ZERO) begin
      base_s = ext_bias_s;
    end else begin
      base_s = acc_r;
    end
    sum_s  = base_s + ext_data_s;
    last_s = (count_r == CNT_LAST);
    sat_s  = sat_fn(sum_s);
  end

  // Window control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= CNT_ZERO;
      acc_r       <= {AW{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_sat_r   <= 1'b0;
    end else if (state_r == IDLE) begin
      state_r    <= ACCUM;
      in_ready_r <= 1'b1;
    end else if (clear) begin
      state_r     <= ACCUM;
      count_r     <= CNT_ZERO;
      acc_r       <= {AW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_sat_r   <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (in_valid) begin
            if (last_s) begin
              out_data_r  <= sat_s[W-1:0];
              out_sat_r   <= sat_s[W];
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
              count_r     <= CNT_ZERO;
              acc_r       <= {AW{1'b0}};
              state_r     <= HOLD;
            end else begin
              acc_r   <= sum_s;
              count_r <= count_r + CNT_ONE;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ACCUM;
          end
        end
        default: begin
          state_r     <= IDLE;
          count_r     <= CNT_ZERO;
          acc_r       <= {AW{1'b0}};
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sat   = out_sat_r;

endmodule
